// File: rtl/hist_eq_frame_ctrl.sv
// Frame sequencer: streams a source frame into hist_eq_core via a 4-deep credit-gated FIFO
// and writes the equalized stream out; first read 1 cycle after start, stalls on core/dst ready.
module hist_eq_frame_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic              err_over,
  output logic [15:0]       frame_cnt,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [7:0]        src_rd_data,
  output logic              core_valid,
  output logic [7:0]        core_gray,
  output logic              core_end,
  input  logic              core_in_ready,
  input  logic              core_out_valid,
  input  logic [7:0]        core_gray_eq,
  input  logic              core_done,
  output logic              core_out_ready,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_wr_addr,
  output logic [7:0]        dst_wr_data,
  input  logic              dst_wr_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(WIDTH * HEIGHT);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] src_base_q;
  logic [ADDR_W-1:0] dst_base_q;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   in_cnt;
  logic [ADDR_W:0]   out_cnt;
  logic [ADDR_W:0]   out_cnt_nxt;
  logic              rd_pend;
  logic [7:0]        fifo_mem [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        fifo_cnt;
  logic [2:0]        reserved;
  logic [2:0]        credit_used;
  logic              push;
  logic              pop;
  logic              rd_issue;
  logic              end_acc;
  logic              out_ok;
  logic              done_seen;
  logic              done_seen_nxt;
  logic              finish;
  logic              err_short_q;
  logic              err_over_q;
  logic [15:0]       frame_cnt_q;

  assign busy      = (state == S_FEED) || (state == S_DRAIN);
  assign done      = (state == S_FIN);
  assign err_short = err_short_q;
  assign err_over  = err_over_q;
  assign frame_cnt = frame_cnt_q;

  // Read data lands exactly one cycle after the strobe, so the pending flag is the push.
  assign push        = rd_pend;
  assign core_valid  = (fifo_cnt != 3'd0);
  assign core_gray   = core_valid ? fifo_mem[rd_ptr] : 8'd0;
  assign core_end    = core_valid && (in_cnt == TOTAL - 1'b1);
  assign pop         = core_valid && core_in_ready;
  assign end_acc     = pop && core_end;

  // A same-cycle pop returns its credit to this cycle's issue decision.
  assign reserved    = fifo_cnt + {2'b00, rd_pend};
  assign credit_used = reserved - {2'b00, pop};
  assign rd_issue    = (state == S_FEED) && (rd_cnt < TOTAL) && (credit_used < 3'd4);
  assign src_rd_en   = rd_issue;
  assign src_rd_addr = src_base_q + rd_cnt[ADDR_W-1:0];

  assign out_ok         = (out_cnt < TOTAL);
  assign core_out_ready = dst_wr_ready && busy && out_ok;
  assign dst_wr_en      = core_out_valid && core_out_ready;
  assign dst_wr_addr    = dst_base_q + out_cnt[ADDR_W-1:0];
  assign dst_wr_data    = dst_wr_en ? core_gray_eq : 8'd0;

  assign out_cnt_nxt   = out_cnt + (ADDR_W+1)'(dst_wr_en);
  assign done_seen_nxt = done_seen || (core_done && (state != S_IDLE));
  assign finish        = (out_cnt_nxt == TOTAL) && done_seen_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FEED;
      S_FEED:  if (end_acc) state_nxt = finish ? S_FIN : S_DRAIN;
      S_DRAIN: if (finish) state_nxt = S_FIN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= src_rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      rd_cnt      <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      rd_pend     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      done_seen   <= 1'b0;
      err_short_q <= 1'b0;
      err_over_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_issue;
      if (state == S_IDLE) begin
        if (start) begin
          src_base_q  <= src_base;
          dst_base_q  <= dst_base;
          rd_cnt      <= '0;
          in_cnt      <= '0;
          out_cnt     <= '0;
          done_seen   <= 1'b0;
          err_short_q <= 1'b0;
          err_over_q  <= 1'b0;
        end
      end else begin
        if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
        if (pop) in_cnt <= in_cnt + 1'b1;
        out_cnt   <= out_cnt_nxt;
        done_seen <= done_seen_nxt;
        if (core_done && out_ok) err_short_q <= 1'b1;
        // Surplus output is left unacknowledged; the core sees it stall.
        if (busy && core_out_valid && !out_ok) err_over_q <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
      if (state == S_FIN) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
// Bench for hist_eq_frame_ctrl on a 4x2 frame; the core is modelled as a bitwise-invert stage.
module tb_hist_eq_frame_ctrl;
  localparam int W = 4;
  localparam int H = 2;
  localparam int AW = 8;
  localparam int TOTAL = W * H;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] src_base, dst_base;
  logic          busy, done, err_short, err_over;
  logic [15:0]   frame_cnt;
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [7:0]    src_rd_data;
  logic          core_valid, core_end, core_in_ready;
  logic [7:0]    core_gray;
  logic          core_out_valid, core_done, core_out_ready;
  logic [7:0]    core_gray_eq;
  logic          dst_wr_en, dst_wr_ready;
  logic [AW-1:0] dst_wr_addr;
  logic [7:0]    dst_wr_data;

  hist_eq_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .err_short(err_short), .err_over(err_over), .frame_cnt(frame_cnt),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .core_valid(core_valid), .core_gray(core_gray), .core_end(core_end),
    .core_in_ready(core_in_ready), .core_out_valid(core_out_valid), .core_gray_eq(core_gray_eq),
    .core_done(core_done), .core_out_ready(core_out_ready), .dst_wr_en(dst_wr_en),
    .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data), .dst_wr_ready(dst_wr_ready)
  );

  always #5 clk = ~clk;

  logic [7:0]    src_mem [256];
  logic [7:0]    core_q [$];
  wr_t           exp_q [$];
  logic [AW-1:0] cur_src;
  int checks, errors, cyc;
  int nreads, in_acc, nwrites, end_cnt, end_idx, max_res_all;
  int done_cnt, done_cyc, done_busy, writes_at_done, last_wr_cyc, cdone_cyc;
  int first_rd_cyc, last_rd_cyc, emitted, done_at, over_ready_seen, base;
  bit rand_mode, extra_mode, extra_pend, done_sent, core_end_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    core_q.delete();
    emitted = 0; core_end_seen = 0; done_sent = 0; extra_pend = 0;
    core_done = 1'b0; core_out_valid = 1'b0; over_ready_seen = -1;
  endtask

  task automatic frame_clear();
    model_clear();
    nreads = 0; in_acc = 0; nwrites = 0; end_cnt = 0; end_idx = -1;
  endtask

  // One clock: sample at negedge, then advance model and drive inputs #1 after posedge.
  task automatic step();
    logic in_fire, out_fire, rd_s, end_s, rst_s;
    logic [AW-1:0] rd_addr_s, exp_ra;
    logic [7:0] gray_s;
    wr_t want;
    @(negedge clk);
    cyc++;
    rst_s = rst_n;
    in_fire = core_valid & core_in_ready;
    out_fire = core_out_valid & core_out_ready;
    gray_s = core_gray; end_s = core_end;
    rd_s = src_rd_en; rd_addr_s = src_rd_addr;
    if (rst_s) begin
      if (rd_s) begin
        exp_ra = cur_src + AW'(nreads);
        chk("rd_addr", rd_addr_s, exp_ra);
        if (nreads == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        nreads++;
      end
      if (in_fire) begin
        if (end_s) begin end_cnt++; end_idx = in_acc; end
        in_acc++;
      end
      if (nreads - in_acc > max_res_all) max_res_all = nreads - in_acc;
      if (dst_wr_en) begin
        chk("wr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          chk("wr_addr", dst_wr_addr, want.addr);
          chk("wr_data", dst_wr_data, want.data);
        end
        nwrites++; last_wr_cyc = cyc;
      end
      if (core_done) cdone_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; writes_at_done = nwrites; end
      if (extra_pend && busy && over_ready_seen < 0) over_ready_seen = core_out_ready;
    end
    @(posedge clk);
    #1;
    if (!rst_s) model_clear();
    else begin
      if (in_fire) begin
        core_q.push_back(~gray_s);
        if (end_s) core_end_seen = 1;
      end
      if (out_fire) begin void'(core_q.pop_front()); emitted++; end
      core_done = 1'b0;
      if (!done_sent && ((done_at >= 0 && emitted == done_at) || (core_end_seen && emitted == TOTAL))) begin
        core_done = 1'b1; done_sent = 1;
      end
      if (extra_mode && !extra_pend && emitted == TOTAL) begin
        core_q.push_back(8'h99); extra_pend = 1;
      end
      core_out_valid = (core_q.size() > 0);
    end
    src_rd_data = rd_s ? src_mem[rd_addr_s] : 8'($urandom);
    core_gray_eq = core_out_valid ? core_q[0] : 8'($urandom);
    if (rand_mode) begin
      core_in_ready = 1'($urandom_range(0, 1));
      dst_wr_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] sb, input logic [AW-1:0] db);
    frame_clear();
    src_base = sb; dst_base = db; cur_src = sb;
    for (int i = 0; i < TOTAL; i++) exp_q.push_back({db + AW'(i), ~src_mem[sb + AW'(i)]});
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) step();
    chk({tag, "_done_pulse"}, done_cnt - d0, 1);
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_writes"}, nwrites, TOTAL);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
    chk({tag, "_reads"}, nreads, TOTAL);
    chk({tag, "_end_count"}, end_cnt, 1);
    chk({tag, "_end_index"}, end_idx, TOTAL - 1);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_short"}, err_short, 0);
    chk({tag, "_err_over"}, err_over, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_src_rd_en"}, src_rd_en, 0);
    chk({tag, "_src_rd_addr"}, src_rd_addr, 0);
    chk({tag, "_core_valid"}, core_valid, 0);
    chk({tag, "_core_gray"}, core_gray, 0);
    chk({tag, "_core_end"}, core_end, 0);
    chk({tag, "_core_out_ready"}, core_out_ready, 0);
    chk({tag, "_dst_wr_en"}, dst_wr_en, 0);
    chk({tag, "_dst_wr_addr"}, dst_wr_addr, 0);
    chk({tag, "_dst_wr_data"}, dst_wr_data, 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    exp_q.delete();
    frame_clear();
    step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; done_cnt = 0; max_res_all = 0;
    done_cyc = 0; done_busy = 0; writes_at_done = 0; last_wr_cyc = 0; cdone_cyc = 0;
    first_rd_cyc = 0; last_rd_cyc = 0; done_at = -1; rand_mode = 0; extra_mode = 0;
    rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; cur_src = '0;
    src_rd_data = '0; core_gray_eq = '0; core_in_ready = 1'b1; dst_wr_ready = 1'b1;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom);
    frame_clear();
    #1;
    repeat (3) step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Directed 4x2 frame, all readies high: latency, addresses, end marker, done timing.
    start_frame(8'h10, 8'h40);
    chk("t1_busy_c1", busy, 1);
    chk("t1_rd_en_c1", src_rd_en, 1);
    chk("t1_valid_c1", core_valid, 0);
    step();
    chk("t1_valid_c2", core_valid, 0);
    step();
    chk("t1_valid_c3", core_valid, 1);
    wait_done("t1", 100);
    frame_checks("t1");
    chk("t1_done_timing", done_cyc, (last_wr_cyc > cdone_cyc ? last_wr_cyc : cdone_cyc) + 1);
    chk("t1_busy_at_done", done_busy, 0);
    chk("t1_read_burst", last_rd_cyc - first_rd_cyc, TOTAL - 1);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_err_short", err_short, 0);
    chk("t1_err_over", err_over, 0);

    // Random core/destination readiness over many frames.
    rand_mode = 1;
    for (int f = 0; f < 20; f++) begin
      start_frame(8'($urandom), 8'($urandom));
      wait_done("t2", 400);
      frame_checks("t2");
      chk("t2_err_short", err_short, 0);
      chk("t2_err_over", err_over, 0);
    end
    rand_mode = 0; core_in_ready = 1'b1; dst_wr_ready = 1'b1;
    step();
    chk("t2_reserved_max", max_res_all <= 4, 1);
    chk("t2_frame_cnt", frame_cnt, 21);

    // Start pulsed mid-frame is ignored; then back-to-back frames.
    reset_dut();
    base = done_cnt;
    start_frame(8'h20, 8'h80);
    repeat (3) step();
    src_base = 8'hAA; dst_base = 8'h11; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t3a", 100);
    frame_checks("t3a");
    start_frame(8'h30, 8'h90);
    chk("t3b_busy_after_b2b_start", busy, 1);
    wait_done("t3b", 100);
    frame_checks("t3b");
    repeat (5) step();
    chk("t3_done_total", done_cnt - base, 2);
    chk("t3_frame_cnt", frame_cnt, 2);

    // Core signals done after only 5 outputs.
    done_at = 5;
    start_frame(8'h00, 8'hC0);
    wait_done("t4", 100);
    frame_checks("t4");
    chk("t4_err_short", err_short, 1);
    chk("t4_err_over", err_over, 0);
    chk("t4_writes_at_done", writes_at_done, TOTAL);
    done_at = -1;

    // Core offers a 9th output.
    extra_mode = 1;
    start_frame(8'h50, 8'h60);
    wait_done("t5", 100);
    frame_checks("t5");
    chk("t5_err_over", err_over, 1);
    chk("t5_err_short", err_short, 0);
    chk("t5_ready_on_extra", over_ready_seen, 0);
    step();
    chk("t5_no_write_in_idle", dst_wr_en, 0);
    extra_mode = 0;

    // Reset during FEED, then a clean frame.
    start_frame(8'h70, 8'h20);
    for (int i = 0; i < 50 && in_acc < 3; i++) step();
    chk("t6_reach_px3", in_acc >= 3, 1);
    rst_n = 1'b0;
    step();
    check_reset_vals("t6");
    rst_n = 1'b1;
    exp_q.delete();
    frame_clear();
    step();
    start_frame(8'h70, 8'h20);
    wait_done("t6", 100);
    frame_checks("t6");
    chk("t6_err_short", err_short, 0);
    chk("t6_err_over", err_over, 0);
    chk("t6_frame_cnt", frame_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
